regfile_scoreboard: RTL

//   Parametrised multi-read-port register file with an integrated per-register busy scoreboard
//   and optional write-to-read bypass. It is the next-generation architectural register file for the pipelined core.
//   It sits between decode/issue, which reads operands and marks destinations busy, and writeback,

---
 rtl/regfile_scoreboard_if.sv | 49 ++++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundles the register-file/scoreboard signals shared by decode/issue,
//   writeback and hazard logic. clk and reset stay outside as plain ports.
//
//   Handshake semantics: every strobe here (wr_en, issue_en, flush) is a
//   single-cycle command qualified only by itself and sampled at the rising
//   clock edge. There is no backpressure; the register file always accepts.
//   Read ports are pure combinational lookups with no strobe.
//
//   Signals
//     rd_addr    NRD*AW    read addresses, port k = [k*AW +: AW]
//     rd_data    NRD*XLEN  read data,      port k = [k*XLEN +: XLEN]
//     rd_busy    NRD       pending-result flag per read port
//     wr_en/wr_addr/wr_data    writeback command
//     issue_en/issue_addr      mark destination busy
//     flush      clear all busy bits, data kept
//     busy_count number of busy registers
//   Modports: master = pipeline side, slave = register file.
// ----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1;
   localparam int CW = $clog2(NREGS + 1);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_addr;
   logic                flush;
   logic [CW-1:0]       busy_count;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      input  rd_data, rd_busy, busy_count
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      output rd_data, rd_busy, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   Multi-read-port architectural register file with a per-register busy
//   scoreboard and optional same-cycle writeback bypass.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears data, busy bits and count
//     bus    regfile_scoreboard_if.slave (reads, writeback, issue, flush,
//            busy_count). XLEN/NREGS/NRD must match the interface instance.
//
//   Parameters
//     ZERO_REG  1: register 0 reads as zero and can never become busy
//     BYPASS    1: a writeback in flight is forwarded to matching read ports
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  bus
);
   localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1;
   localparam int CW = $clog2(NREGS + 1);

   logic [XLEN-1:0]     regs_q [NREGS];
   logic [NREGS-1:0]    busy_q;
   logic [NREGS-1:0]    busy_d;
   logic [CW-1:0]       busy_count_q;
   logic [CW-1:0]       busy_count_d;
   logic                wr_ok;
   logic                iss_ok;
   logic [AW-1:0]       rd_a;
   logic [NRD*XLEN-1:0] rd_data_d;
   logic [NRD-1:0]      rd_busy_d;

   // Addresses that are not real storage: the hardwired zero register and
   // anything past NREGS (NREGS need not be a power of two). The widening
   // cast keeps the range test meaningful for every NREGS.
   function automatic logic excluded(input logic [AW-1:0] addr);
      return ((ZERO_REG != 0) && (addr == '0)) || (32'(addr) >= 32'(NREGS));
   endfunction

   assign wr_ok  = bus.wr_en    && !excluded(bus.wr_addr);
   assign iss_ok = bus.issue_en && !excluded(bus.issue_addr);

   // Later assignments win: issue set > writeback clear > flush clear.
   always_comb begin
      busy_d = busy_q;
      if (bus.flush) busy_d = '0;
      if (wr_ok)     busy_d[bus.wr_addr]    = 1'b0;
      if (iss_ok)    busy_d[bus.issue_addr] = 1'b1;
   end

   // Count is taken from next-state busy so it moves on the same edge.
   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_count_d = busy_count_d + CW'(busy_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Read ports. Issue is deliberately never forwarded: a freshly issued
   // destination only shows busy from the following cycle.
   always_comb begin
      rd_data_d = '0;
      rd_busy_d = '0;
      rd_a      = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_a = bus.rd_addr[k*AW +: AW];
         if (!excluded(rd_a)) begin
            if ((BYPASS != 0) && wr_ok && (bus.wr_addr == rd_a)) begin
               rd_data_d[k*XLEN +: XLEN] = bus.wr_data;
               rd_busy_d[k]              = 1'b0;
            end else begin
               rd_data_d[k*XLEN +: XLEN] = regs_q[rd_a];
               rd_busy_d[k]              = busy_q[rd_a];
            end
         end
      end
   end

   assign bus.rd_data    = rd_data_d;
   assign bus.rd_busy    = rd_busy_d;
   assign bus.busy_count = busy_count_q;
endmodule
